if_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and supplies the 32-bit instruction word whose opcode field drives the main control decoder.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards stale in-flight fetches.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, credit-limited in-order fetch, flushable instruction FIFO.
// Optional IF_PERF_EN adds perf_fetched / perf_bubble counters.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [0:0] S_BOOT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW:0]   w_credit_used;
    logic [CW-1:0] w_outstanding_next;

    assign w_empty       = (r_count == '0);
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};

    assign imem_req_valid = !rst && (r_state == S_RUN) && !redirect_valid
                            && (w_credit_used < {1'b0, DEPTH_C});
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = (r_drop != '0);
    assign w_push     = imem_rsp_valid && !w_rsp_drop && !redirect_valid && !rst;

    assign id_valid = !rst && !w_empty;
    assign w_pop    = id_valid && id_ready && !redirect_valid;
    assign id_instr = id_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign id_pc    = id_valid ? r_fifo_pc[r_rd_ptr] : '0;

    // Total in flight, stale requests included; a same-cycle response is already subtracted.
    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            // In-flight count survives reset so responses to pre-reset requests are recognised and dropped.
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_outstanding_next;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_state       <= S_RUN;
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_pc      <= redirect_pc;
                r_resp_pc <= redirect_pc;
                r_drop    <= w_outstanding_next;
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (imem_rsp_valid && w_rsp_drop) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (id_ready && !id_valid && (r_state == S_RUN)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubble  = r_perf_bubble;
`endif

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == DEPTH_C)));
    a_redirect_aligned: assert property (@(posedge clk) disable iff (rst)
        !(redirect_valid && (redirect_pc[1:0] != 2'b00)));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (r_outstanding == '0)));

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed phases drive a behavioural in-order memory,
// expected PCs are queued by the driver and checked by an independent decode-side monitor.
module tb_if_stage;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    logic [31:0] exp_q[$];
    logic [31:0] infl_addr[$];
    int          infl_due[$];

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
`ifdef IF_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubble   (perf_bubble)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: opcode alternates 0x13 / 0x33 with address bit 2, upper bits tag the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        instr_of = {a[26:2], (a[2] ? 7'h33 : 7'h13)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_restart(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_consumed(input int n, input string name);
        int target = consumed + n;
        int k = 0;
        while (consumed < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (consumed < target) begin
            errors++;
            $display("FAIL %s: consumed %0d of required %0d before timeout", name,
                     consumed - (target - n), n);
        end
    endtask

    // Fixed-latency in-order memory, never back-pressures responses.
    initial begin
        logic        hs;
        logic [31:0] ha;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            ha = imem_req_addr;
            @(posedge clk);
            #1;
            if (hs) begin
                infl_addr.push_back(ha);
                infl_due.push_back(cyc - 1 + mem_lat);
            end
            if (infl_addr.size() != 0 && infl_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(infl_addr.pop_front());
                void'(infl_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Decode-side monitor: every accepted instruction is matched against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready && !redirect_valid) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h with nothing expected", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_instr", id_instr, instr_of(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          base_consumed;
        logic        found;
        logic        pat [5];
        logic [31:0] ea  [5];

        rst            = 1'b1;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset outputs
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);

        // Release: BOOT at cycle 0, first request at cycle 1, first instruction at cycle 3
        tick();
        rst = 1'b0;
        sb_restart(32'h0);
        @(negedge clk);
        chk("boot_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c1_req_addr", imem_req_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("c2_id_valid", 32'(id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c3_id_valid", 32'(id_valid), 32'd1);
        chk("c3_id_pc", id_pc, 32'h0);
        chk("c3_opcode", 32'(id_instr[6:0]), 32'h13);
        tick();
        wait_consumed(8, "initial_stream");

        // Decode stall: credit limit caps requests
        id_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_req_le_depth", 32'(n <= DEPTH), 32'd1);
        tick();
        id_ready = 1'b1;
        wait_consumed(6, "stall_resume");

        // Redirect with two stale requests in flight, 3-cycle memory
        id_ready = 1'b0;
        repeat (4) tick();
        mem_lat        = 3;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        sb_restart(32'h40);
        @(negedge clk);
        chk("redir_cycle_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_first_req_addr", imem_req_addr, 32'h40);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb_restart(32'h100);
        @(negedge clk);
        chk("two_in_flight", 32'(infl_addr.size()), 32'd2);
        chk("redir2_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        wait_consumed(4, "after_stale_drop");

        // Redirect coinciding with a response and a decode accept
        id_ready = 1'b0;
        repeat (8) tick();
        mem_lat  = 1;
        id_ready = 1'b1;
        found    = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk);
            #2;
            if (imem_rsp_valid && id_valid) found = 1'b1;
        end
        chk("rsp_and_valid_seen", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sb_restart(32'h200);
        @(negedge clk);
        chk("same_cycle_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("same_cycle_fifo_empty", 32'(id_valid), 32'd0);
        chk("same_cycle_next_req", 32'(imem_req_valid), 32'd1);
        chk("same_cycle_next_addr", imem_req_addr, 32'h200);
        tick();
        wait_consumed(3, "after_same_cycle");

        // imem_req_ready toggling
        id_ready = 1'b0;
        repeat (4) tick();
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        sb_restart(32'h300);
        @(negedge clk);
        chk("toggle_redir_no_req", 32'(imem_req_valid), 32'd0);
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ea  = '{32'h300, 32'h304, 32'h304, 32'h308, 32'h308};
        for (int i = 0; i < 5; i++) begin
            tick();
            redirect_valid = 1'b0;
            imem_req_ready = pat[i];
            @(negedge clk);
            chk("toggle_req_valid", 32'(imem_req_valid), 32'd1);
            chk("toggle_req_addr", imem_req_addr, ea[i]);
        end
        tick();
        imem_req_ready = 1'b1;
        wait_consumed(4, "after_toggle");

        // Reset mid-stream with one request outstanding
        id_ready = 1'b0;
        repeat (4) tick();
        mem_lat        = 3;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        sb_restart(32'h400);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("pre_rst_req_addr", imem_req_addr, 32'h400);
        tick();
        rst = 1'b1;
        sb_restart(32'h0);
        @(negedge clk);
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_id_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_id_instr", id_instr, 32'd0);
        chk("mid_rst_id_pc", id_pc, 32'd0);
        tick();
        rst = 1'b0;
        base_consumed = consumed;
`ifdef IF_PERF_EN
        @(negedge clk);
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_bubble_rst", perf_bubble, 32'd0);
`endif
        wait_consumed(4, "after_reset");
`ifdef IF_PERF_EN
        chk("perf_fetched_count", perf_fetched, 32'(consumed - base_consumed));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
